regbank: RTL and testbench

REGBANK -- requirements
Module: regbank

---
 rtl/regbank_pkg.sv | 20 ++
 rtl/regbank_cell.sv | 72 +++++++
 rtl/regbank.sv | 87 ++++++++
 tb/tb_regbank.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared constants and helpers for the regbank register file.
// The shadow-bank option is selected with REGBANK_SHADOW_EN in the users of this package.
package regbank_pkg;

  localparam int REGBANK_DATAW_DEFAULT = 32;
  localparam int REGBANK_NREGS_DEFAULT = 8;

  // Byte-enable merge: take the new byte when enabled, otherwise keep the old one.
  function automatic logic [7:0] be_merge_byte(input logic [7:0] old_b,
                                               input logic [7:0] new_b,
                                               input logic       en);
    return en ? new_b : old_b;
  endfunction

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned nregs);
    return addr < 32'(nregs);
  endfunction

endpackage

// File: rtl/regbank_cell.sv
// One DATAW-wide register with byte-enabled write. With REGBANK_SHADOW_EN defined,
// writes land in a shadow stage that is copied to the active stage on i_commit.
module regbank_cell
  import regbank_pkg::*;
#(
  parameter int DATAW = REGBANK_DATAW_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [DATAW/8-1:0] i_be,
  input  logic [DATAW-1:0]   i_wdata,
`ifdef REGBANK_SHADOW_EN
  input  logic               i_commit,
`endif
  output logic [DATAW-1:0]   o_active,
  output logic [DATAW-1:0]   o_rd
);

  localparam int NB = DATAW / 8;

  logic [DATAW-1:0] active_q, active_d;
  logic [DATAW-1:0] wr_base, wr_merged;

`ifdef REGBANK_SHADOW_EN
  logic [DATAW-1:0] shadow_q, shadow_d;
  assign wr_base = shadow_q;
`else
  assign wr_base = active_q;
`endif

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign wr_merged[b*8 +: 8] = be_merge_byte(wr_base[b*8 +: 8], i_wdata[b*8 +: 8], i_be[b]);
  end

`ifdef REGBANK_SHADOW_EN
  // Commit copies the post-write shadow value, so a same-cycle write is included.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (i_we)     shadow_d = wr_merged;
    if (i_commit) active_d = shadow_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign o_rd = shadow_q;
`else
  always_comb begin
    active_d = active_q;
    if (i_we) active_d = wr_merged;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) active_q <= '0;
    else       active_q <= active_d;
  end

  assign o_rd = active_q;
`endif

  assign o_active = active_q;

endmodule

// File: rtl/regbank.sv
// Byte-enabled register bank with single-cycle acknowledged accesses.
// Define REGBANK_SHADOW_EN to add a shadow bank and the i_commit transfer strobe.
module regbank
  import regbank_pkg::*;
#(
  parameter int DATAW = REGBANK_DATAW_DEFAULT,
  parameter int NREGS = REGBANK_NREGS_DEFAULT,
  parameter int ADDRW = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req,
  input  logic                   i_we,
  input  logic [ADDRW-1:0]       i_addr,
  input  logic [DATAW-1:0]       i_wdata,
  input  logic [DATAW/8-1:0]     i_be,
`ifdef REGBANK_SHADOW_EN
  input  logic                   i_commit,
`endif
  output logic                   o_ack,
  output logic                   o_err,
  output logic [DATAW-1:0]       o_rdata,
  output logic [NREGS*DATAW-1:0] o_regs
);

  logic [NREGS-1:0][DATAW-1:0] active;
  logic [NREGS-1:0][DATAW-1:0] rd;
  logic [NREGS-1:0]            we;
  logic [DATAW-1:0]            rd_sel;
  logic                        in_range;

  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [DATAW-1:0] rdata_q, rdata_d;

  assign in_range = addr_in_range(32'(i_addr), NREGS);

  for (genvar k = 0; k < NREGS; k++) begin : g_cell
    assign we[k] = i_req & i_we & (i_addr == ADDRW'(k));

    regbank_cell #(.DATAW(DATAW)) u_cell (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_we     (we[k]),
      .i_be     (i_be),
      .i_wdata  (i_wdata),
`ifdef REGBANK_SHADOW_EN
      .i_commit (i_commit),
`endif
      .o_active (active[k]),
      .o_rd     (rd[k])
    );

    assign o_regs[k*DATAW +: DATAW] = active[k];
  end

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NREGS; k++)
      if (i_addr == ADDRW'(k)) rd_sel = rd[k];
  end

  always_comb begin
    ack_d   = i_req;
    err_d   = i_req & ~in_range;
    rdata_d = '0;
    if (i_req && !i_we && in_range) rdata_d = rd_sel;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // A reset arriving in the ack cycle swallows the pending response.
  assign o_ack   = ack_q & ~i_rst;
  assign o_err   = err_q & ~i_rst;
  assign o_rdata = i_rst ? '0 : rdata_q;

endmodule

// File: tb/tb_regbank.sv
// Scoreboard bench for regbank: a byte-level model pushes expected responses, a
// negedge monitor pops and compares them and checks o_regs every cycle.
module tb_regbank;

  localparam int DATAW = 32;
  localparam int NREGS = 8;
  localparam int ADDRW = 8;
  localparam int NB    = DATAW / 8;
`ifdef REGBANK_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  typedef struct packed {
    logic             err;
    logic [DATAW-1:0] rdata;
  } exp_t;

  logic                   i_clk = 1'b0;
  logic                   i_rst, i_req, i_we, i_commit;
  logic [ADDRW-1:0]       i_addr;
  logic [DATAW-1:0]       i_wdata;
  logic [NB-1:0]          i_be;
  logic                   o_ack, o_err;
  logic [DATAW-1:0]       o_rdata;
  logic [NREGS*DATAW-1:0] o_regs;

  always #5 i_clk = ~i_clk;

  regbank #(.DATAW(DATAW), .NREGS(NREGS), .ADDRW(ADDRW)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (i_req),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .i_be    (i_be),
`ifdef REGBANK_SHADOW_EN
    .i_commit(i_commit),
`endif
    .o_ack   (o_ack),
    .o_err   (o_err),
    .o_rdata (o_rdata),
    .o_regs  (o_regs)
  );

  logic [DATAW-1:0] act_m [NREGS];
  logic [DATAW-1:0] shd_m [NREGS];
  exp_t             exp_q [$];
  int               nvec = 0;
  int               nerr = 0;

  // Reference model: evaluated at every rising edge from the sampled inputs.
  exp_t m_e;
  int   m_a;
  always @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NREGS; k++) begin
        act_m[k] = '0;
        shd_m[k] = '0;
      end
      exp_q.delete();
    end else begin
      if (i_req) begin
        m_e.err   = (int'(i_addr) >= NREGS);
        m_e.rdata = '0;
        if (!m_e.err) begin
          m_a = int'(i_addr);
          if (!i_we) begin
            m_e.rdata = SHADOW ? shd_m[m_a] : act_m[m_a];
          end else begin
            for (int b = 0; b < NB; b++)
              if (i_be[b]) begin
                if (SHADOW) shd_m[m_a][b*8 +: 8] = i_wdata[b*8 +: 8];
                else        act_m[m_a][b*8 +: 8] = i_wdata[b*8 +: 8];
              end
          end
        end
        exp_q.push_back(m_e);
      end
      if (SHADOW && i_commit)
        for (int k = 0; k < NREGS; k++) act_m[k] = shd_m[k];
    end
  end

  // Monitor: each response is due in the cycle after its request.
  exp_t             c_e;
  bit               c_have;
  logic [NREGS*DATAW-1:0] c_regs;
  always @(negedge i_clk) begin
    c_have = (exp_q.size() > 0);
    if (c_have) c_e = exp_q.pop_front();
    if (c_have && i_rst) c_have = 1'b0;
    nvec++;
    if (o_ack !== c_have) begin
      nerr++;
      $display("FAIL ack @%0t: got %b expected %b", $time, o_ack, c_have);
    end else if (c_have) begin
      nvec++;
      if (o_err !== c_e.err || o_rdata !== c_e.rdata) begin
        nerr++;
        $display("FAIL resp @%0t: got err=%b rdata=%h expected err=%b rdata=%h",
                 $time, o_err, o_rdata, c_e.err, c_e.rdata);
      end
    end else if (o_err !== 1'b0 || o_rdata !== '0) begin
      nerr++;
      $display("FAIL idle @%0t: got err=%b rdata=%h expected 0/0", $time, o_err, o_rdata);
    end
    for (int k = 0; k < NREGS; k++) c_regs[k*DATAW +: DATAW] = act_m[k];
    nvec++;
    if (o_regs !== c_regs) begin
      nerr++;
      $display("FAIL regs @%0t: got %h expected %h", $time, o_regs, c_regs);
    end
  end

  task automatic step(input logic req, input logic we, input logic [ADDRW-1:0] addr,
                      input logic [DATAW-1:0] wd, input logic [NB-1:0] be,
                      input logic rst, input logic commit);
    i_req    = req;
    i_we     = we;
    i_addr   = addr;
    i_wdata  = wd;
    i_be     = be;
    i_rst    = rst;
    i_commit = commit;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = '0;
    i_wdata = '0; i_be = '0; i_commit = 1'b0;
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Reads of every register straight out of reset.
    for (int k = 0; k < NREGS; k++) step(1'b1, 1'b0, ADDRW'(k), '0, '0, 1'b0, 1'b0);

    // Partial byte write merging into an existing value.
    step(1'b1, 1'b1, 8'd3, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'd3, 32'h000000AA, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'd3, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'd3, 32'h12345678, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'd3, '0, '0, 1'b0, 1'b0);

    // Back-to-back write then read.
    step(1'b1, 1'b1, 8'd2, 32'h00000011, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'd2, '0, '0, 1'b0, 1'b0);

    // Out-of-range accesses.
    step(1'b1, 1'b1, 8'(NREGS), 32'hFFFFFFFF, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hFF, '0, '0, 1'b0, 1'b0);
    idle(1);

    // Request dropped with reset, and request whose ack falls in a reset cycle.
    step(1'b1, 1'b1, 8'd4, 32'hCAFEF00D, 4'b1111, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'd2, '0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'd3, '0, '0, 1'b0, 1'b0);

`ifdef REGBANK_SHADOW_EN
    step(1'b1, 1'b1, 8'd1, 32'h00000055, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'd1, '0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'd5, 32'hA5A5A5A5, 4'b0110, 1'b0, 1'b1);
    idle(1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
           ADDRW'($urandom_range(0, NREGS + 2)), DATAW'($urandom), NB'($urandom),
           1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) == 0));

    idle(2);
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
